// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the instruction control sequencer: state encoding,
// opcode constants and IR field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StHalt = 4'd7
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RA_HI  = 26;
    localparam int unsigned RA_LO  = 23;
    localparam int unsigned RB_HI  = 22;
    localparam int unsigned RB_LO  = 19;
    localparam int unsigned RC_HI  = 18;
    localparam int unsigned RC_LO  = 15;

    // Register-to-register ALU opcodes form one contiguous range.
    function automatic logic is_alu(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-bit register field to one-hot select; fields beyond the register count
// select nothing.
module reg_onehot_dec #(
    parameter int NREG = 16
) (
    input  logic            en_i,
    input  logic [3:0]      field_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREG; i++) begin
            onehot_o[i] = en_i && ({28'd0, field_i} == 32'(i));
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control FSM for the datapath: fetch in T0-T2, register-to-register
// ALU execute in T3-T5; strobes are decoded from the registered state and IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_rdy,
    output logic [NREG-1:0] R_rd,
    output logic [NREG-1:0] R_wrt,
    output logic            PC_out,
    output logic            MDR_out,
    output logic            Zlo_out,
    output logic            Zhi_out,
    output logic            HI_out,
    output logic            LO_out,
    output logic            MAR_out,
    output logic            In_out,
    output logic            C_out,
    output logic            PC_rd,
    output logic            MAR_rd,
    output logic            MDR_rd,
    output logic            IR_rd,
    output logic            Y_rd,
    output logic            Zlo_rd,
    output logic            IncPC,
    output logic            Read,
    output logic [OPW-1:0]  op_sel,
    output logic            illegal,
    output logic            halted,
    output logic [3:0]      state_dbg
);

    state_e     state_q, state_d, boundary;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       rd_en, wrt_en;
    logic [3:0] wrt_field;
    logic       unused_ir;

    assign opcode    = ir[OPC_HI:OPC_LO];
    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign rc        = ir[RC_HI:RC_LO];
    assign unused_ir = ^ir[14:0];

    assign boundary = run ? StT0 : StIdle;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (mem_rdy) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (is_alu(opcode))        state_d = StT4;
                else if (opcode == OP_HALT) state_d = StHalt;
                else                        state_d = boundary;
            end
            StT4:   state_d = StT5;
            StT5:   state_d = boundary;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // One decoder serves both register reads: Rb in T3, Rc in T4.
    assign rd_en     = (state_q == StT5);
    assign wrt_en    = ((state_q == StT3) && is_alu(opcode)) || (state_q == StT4);
    assign wrt_field = (state_q == StT4) ? rc : rb;

    reg_onehot_dec #(.NREG(NREG)) u_rd_dec (
        .en_i     (rd_en),
        .field_i  (ra),
        .onehot_o (R_rd)
    );

    reg_onehot_dec #(.NREG(NREG)) u_wrt_dec (
        .en_i     (wrt_en),
        .field_i  (wrt_field),
        .onehot_o (R_wrt)
    );

    assign Zhi_out = 1'b0;
    assign HI_out  = 1'b0;
    assign LO_out  = 1'b0;
    assign MAR_out = 1'b0;
    assign In_out  = 1'b0;
    assign C_out   = 1'b0;
    assign PC_rd   = 1'b0;

    assign state_dbg = state_q;

    always_comb begin
        PC_out  = 1'b0;
        MDR_out = 1'b0;
        Zlo_out = 1'b0;
        MAR_rd  = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        op_sel  = '0;
        illegal = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            StT0: begin
                PC_out = 1'b1;
                MAR_rd = 1'b1;
                IncPC  = 1'b1;
            end
            StT1: begin
                Read   = 1'b1;
                MDR_rd = 1'b1;
            end
            StT2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
            end
            StT3: begin
                if (is_alu(opcode)) begin
                    Y_rd = 1'b1;
                end else if ((opcode != OP_NOP) && (opcode != OP_HALT)) begin
                    illegal = 1'b1;
                end
            end
            StT4: begin
                op_sel = OPW'(opcode);
                Zlo_rd = 1'b1;
            end
            StT5:   Zlo_out = 1'b1;
            StHalt: halted  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, mem_rdy;
    logic [31:0] ir;
    logic [15:0] R_rd, R_wrt;
    logic PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, MAR_out, In_out, C_out;
    logic PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, IncPC, Read;
    logic [4:0]  op_sel;
    logic        illegal, halted;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    control_sequencer #(.NREG(16), .OPW(5)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .R_rd(R_rd), .R_wrt(R_wrt),
        .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
        .HI_out(HI_out), .LO_out(LO_out), .MAR_out(MAR_out), .In_out(In_out),
        .C_out(C_out), .PC_rd(PC_rd), .MAR_rd(MAR_rd), .MDR_rd(MDR_rd),
        .IR_rd(IR_rd), .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .IncPC(IncPC), .Read(Read),
        .op_sel(op_sel), .illegal(illegal), .halted(halted), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [15:0] rrd, rwrt;
        logic pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, mar_out, in_out, c_out;
        logic pc_rd, mar_rd, mdr_rd, ir_rd, y_rd, zlo_rd, inc_pc, read;
        logic [4:0] op_sel;
        logic illegal, halted;
        logic [3:0] st;
    } obs_t;

    obs_t act;
    assign act = {R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, MAR_out,
                  In_out, C_out, PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, IncPC, Read,
                  op_sel, illegal, halted, state_dbg};

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;
    bit    next_t0 = 1'b0;

    // Phase numbers follow the documented state_dbg encoding.
    localparam int PH_IDLE = 0, PH_T0 = 1, PH_T1 = 2, PH_T2 = 3, PH_T3 = 4,
                   PH_T4 = 5, PH_T5 = 6, PH_HALT = 7;

    function automatic obs_t ex(input int ph, input logic [31:0] i);
        obs_t o;
        int   op;
        o    = '0;
        o.st = 4'(ph);
        op   = int'(i[31:27]);
        case (ph)
            PH_T0: begin o.pc_out = 1'b1; o.mar_rd = 1'b1; o.inc_pc = 1'b1; end
            PH_T1: begin o.read = 1'b1; o.mdr_rd = 1'b1; end
            PH_T2: begin o.mdr_out = 1'b1; o.ir_rd = 1'b1; end
            PH_T3: begin
                if (op >= 3 && op <= 11) begin
                    o.rwrt = 16'(1) << i[22:19];
                    o.y_rd = 1'b1;
                end else if (op != 26 && op != 27) begin
                    o.illegal = 1'b1;
                end
            end
            PH_T4: begin
                o.rwrt   = 16'(1) << i[18:15];
                o.op_sel = i[31:27];
                o.zlo_rd = 1'b1;
            end
            PH_T5: begin o.zlo_out = 1'b1; o.rrd = 16'(1) << i[26:23]; end
            PH_HALT: o.halted = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                         t, act, act.st, e, e.st);
            end
        end
    end

    // Drive one cycle's inputs just after the posedge and queue its expected outputs.
    task automatic cyc(input logic r, input logic m, input logic [31:0] i,
                       input obs_t e, input string t);
        run     = r;
        mem_rdy = m;
        ir      = i;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse(input logic [31:0] i, input string t);
        run = 1'($urandom);
        ir  = i;
        clr = 1'b1;
        exp_q.push_back(ex(PH_IDLE, i));
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        clr     = 1'b0;
        next_t0 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'($urandom), $urandom, ex(PH_IDLE, 0), "idle");
    endtask

    task automatic instr(input logic [31:0] iv, input int w, input logic run_end,
                         input bit abort_t4);
        int op;
        op = int'(iv[31:27]);
        if (!next_t0) cyc(1'b1, 1'($urandom), $urandom, ex(PH_IDLE, 0), "idle-start");
        cyc(1'($urandom), 1'($urandom), $urandom, ex(PH_T0, 0), "T0");
        for (int k = 0; k < w; k++) cyc(1'($urandom), 1'b0, $urandom, ex(PH_T1, 0), "T1-wait");
        cyc(1'($urandom), 1'b1, $urandom, ex(PH_T1, 0), "T1");
        cyc(1'($urandom), 1'($urandom), $urandom, ex(PH_T2, 0), "T2");
        if (op >= 3 && op <= 11) begin
            cyc(1'($urandom), 1'($urandom), iv, ex(PH_T3, iv), "T3-alu");
            if (abort_t4) begin
                clr_pulse(iv, "clr-in-T4");
                return;
            end
            cyc(run_end, 1'($urandom), iv, ex(PH_T4, iv), "T4");
            cyc(run_end, 1'($urandom), iv, ex(PH_T5, iv), "T5");
            next_t0 = run_end;
        end else if (op == 27) begin
            cyc(1'($urandom), 1'($urandom), iv, ex(PH_T3, iv), "T3-halt");
            for (int k = 0; k < 6; k++)
                cyc(1'($urandom), 1'($urandom), $urandom, ex(PH_HALT, 0), "halt-hold");
            clr_pulse($urandom, "clr-from-halt");
        end else begin
            cyc(run_end, 1'($urandom), iv, ex(PH_T3, iv), "T3-short");
            next_t0 = run_end;
        end
    endtask

    function automatic logic [31:0] rand_ir();
        int         sel;
        logic [4:0] op;
        logic [31:0] v;
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            op = 5'($urandom_range(3, 11));
        end else if (sel < 8) begin
            op = 5'd26;
        end else begin
            op = 5'($urandom_range(0, 31));
            while ((op >= 5'd3 && op <= 5'd11) || op == 5'd26 || op == 5'd27)
                op = 5'($urandom_range(0, 31));
        end
        v = $urandom;
        v[31:27] = op;
        return v;
    endfunction

    initial begin
        clr     = 1'b1;
        run     = 1'b0;
        mem_rdy = 1'b0;
        ir      = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 32'h0, ex(PH_IDLE, 0), "reset");
        cyc(1'b1, 1'b1, 32'h2A1B8000, ex(PH_IDLE, 0), "reset-run-held");
        clr = 1'b0;

        instr(32'h2A1B8000, 0, 1'b1, 1'b0);
        instr(32'h2A1B8000, 3, 1'b1, 1'b0);
        instr(32'hF8000000, 0, 1'b1, 1'b0);
        instr(32'hD0000000, 1, 1'b1, 1'b0);
        instr(32'h1B3C0000, 2, 1'b0, 1'b0);
        idle(3);
        instr(32'h2A1B8000, 1, 1'b1, 1'b1);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            instr(rand_ir(), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
            if (!next_t0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        instr(32'hD8000000, 2, 1'b1, 1'b0);
        idle(2);

        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
